imm_gen_stage: RTL and testbench

Registered, parametrised immediate-decode stage for the RV32I/RV64I core. Accepts one raw instruction per cycle over a valid/ready handshake and decodes the format from the opcode itself, so no external format select is needed. Emits the sign- or zero-extended immediate at XLEN width with a format tag and an illegal flag. Sits between fetch and register-read, with a 2-entry skid buffer so `in_ready` is registered and never combinationally depends on `out_ready`.

---
 rtl/imm_gen_stage_if.sv | 28 ++
 rtl/imm_gen_stage.sv | 146 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bundle carrying raw instructions into the immediate-decode
// stage and decoded immediates out toward register-read.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_imm,
        input  out_fmt, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_imm,
        output out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate-decode stage: opcode-driven format select, XLEN immediate,
// output register plus skid register so in_ready never sees out_ready.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    imm_gen_stage_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B,
        FMT_U, FMT_J, FMT_SHAMT, FMT_ZIMM
    } fmt_e;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            ill;
    } ent_t;

    logic [31:0] w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [5:0]  f6;
    logic        sh_hi;
    fmt_e        dec_fmt;
    logic        dec_ill;
    logic [31:0] dec_v;
    ent_t        dec_e;

    ent_t o_q, o_d, s_q, s_d;
    logic o_valid_q, o_valid_d;
    logic s_valid_q, s_valid_d;
    logic in_ready_q, in_ready_d;
    logic accept, o_free;

    assign w     = bus.in_inst;
    assign op    = w[6:0];
    assign f3    = w[14:12];
    assign f6    = w[31:26];
    assign sh_hi = (XLEN == 64) ? w[25] : 1'b0;

    // Format and legality from the opcode alone.
    always_comb begin
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (op)
            7'b0000011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 32 && w[25]) dec_ill = 1'b1;
                    if (!(f6 == 6'b000000 ||
                          (f6 == 6'b010000 && f3 == 3'b101)))
                        dec_ill = 1'b1;
                end else begin
                    dec_fmt = FMT_I;
                end
            end
            7'b0100011: dec_fmt = FMT_S;
            7'b1100011: dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111: dec_fmt = FMT_J;
            7'b0110011: dec_fmt = FMT_NONE;
            7'b1110011: dec_fmt = f3[2] ? FMT_ZIMM : FMT_I;
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) dec_fmt = FMT_NONE;
    end

    // 32-bit immediate; zero-extended formats keep bit 31 clear so a
    // single sign-extension to XLEN serves every format.
    always_comb begin
        dec_v = '0;
        case (dec_fmt)
            FMT_I:     dec_v = {{20{w[31]}}, w[31:20]};
            FMT_S:     dec_v = {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:     dec_v = {{19{w[31]}}, w[31], w[7], w[30:25],
                                w[11:8], 1'b0};
            FMT_U:     dec_v = {w[31:12], 12'b0};
            FMT_J:     dec_v = {{11{w[31]}}, w[31], w[19:12], w[20],
                                w[30:21], 1'b0};
            FMT_SHAMT: dec_v = {26'b0, sh_hi, w[24:20]};
            FMT_ZIMM:  dec_v = {27'b0, w[19:15]};
            default:   dec_v = '0;
        endcase
        dec_e.inst = w;
        dec_e.imm  = XLEN'($signed(dec_v));
        dec_e.fmt  = dec_fmt;
        dec_e.ill  = dec_ill;
    end

    assign accept = bus.in_valid & in_ready_q;
    assign o_free = ~o_valid_q | bus.out_ready;

    // Skid steering: S always drains into O before new data lands there.
    always_comb begin
        o_d       = o_q;
        s_d       = s_q;
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;
        if (bus.flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (o_free) begin
            if (s_valid_q) begin
                o_d       = s_q;
                o_valid_d = 1'b1;
                s_valid_d = accept;
                if (accept) s_d = dec_e;
            end else begin
                o_valid_d = accept;
                if (accept) o_d = dec_e;
            end
        end else if (accept) begin
            s_d       = dec_e;
            s_valid_d = 1'b1;
        end
        in_ready_d = ~s_valid_d;
    end

    // State registers; reset clears contents and holds in_ready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q        <= '0;
            s_q        <= '0;
            o_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            o_q        <= o_d;
            s_q        <= s_d;
            o_valid_q  <= o_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = o_valid_q;
    assign bus.out_inst    = o_q.inst;
    assign bus.out_imm     = o_q.imm;
    assign bus.out_fmt     = o_q.fmt;
    assign bus.out_illegal = o_q.ill;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus
// and are compared against a queue-based reference of the stage.
module tb_imm_gen_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rs, fl, iv, ordy;
    logic [31:0] ii;

    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();

    assign b32.flush     = fl;
    assign b32.in_valid  = iv;
    assign b32.in_inst   = ii;
    assign b32.out_ready = ordy;
    assign b64.flush     = fl;
    assign b64.in_valid  = iv;
    assign b64.in_inst   = ii;
    assign b64.out_ready = ordy;

    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rs), .bus(b32));
    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rs), .bus(b64));

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q[$];
    logic        exp_rdy;
    logic        was_rst;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input longint v, input int xlen);
        logic [63:0] r;
        r = 64'(v);
        if (xlen == 32) r[63:32] = '0;
        return r;
    endfunction

    function automatic void ref_dec(input logic [31:0] x, input int xlen,
                                    output logic [63:0] imm,
                                    output logic [2:0] fmt,
                                    output logic ill);
        longint     v;
        logic [6:0] f7;
        logic [2:0] f3;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        f3  = x[14:12];
        f7  = x[31:25];
        case (x[6:0])
            7'h03, 7'h67, 7'h0F: begin
                fmt = 3'd1; v = longint'($signed(x[31:20]));
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    fmt = 3'd6;
                    if (xlen == 64) begin
                        v = longint'(x[25:20]);
                        f7[0] = 1'b0;
                    end else begin
                        v = longint'(x[24:20]);
                        if (x[25]) ill = 1'b1;
                    end
                    if (!(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)))
                        ill = 1'b1;
                end else begin
                    fmt = 3'd1; v = longint'($signed(x[31:20]));
                end
            end
            7'h23: begin
                fmt = 3'd2; v = longint'($signed({x[31:25], x[11:7]}));
            end
            7'h63: begin
                fmt = 3'd3;
                v = longint'($signed({x[31], x[7], x[30:25],
                                      x[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin
                fmt = 3'd4; v = longint'($signed({x[31:12], 12'h000}));
            end
            7'h6F: begin
                fmt = 3'd5;
                v = longint'($signed({x[31], x[19:12], x[20],
                                      x[30:21], 1'b0}));
            end
            7'h33: fmt = 3'd0;
            7'h73: begin
                if (f3[2]) begin
                    fmt = 3'd7; v = longint'(x[19:15]);
                end else begin
                    fmt = 3'd1; v = longint'($signed(x[31:20]));
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            fmt = 3'd0; v = 0;
        end
        imm = sx(v, xlen);
    endfunction

    task automatic chk_dut(input string nm, input int xlen,
                           input logic v, input logic r,
                           input logic [31:0] inst, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic ill);
        logic [63:0] ei;
        logic [2:0]  ef;
        logic        el;
        check({nm, ".in_ready"}, 64'(r), 64'(exp_rdy));
        check({nm, ".out_valid"}, 64'(v), 64'(q.size() > 0));
        if (was_rst) begin
            check({nm, ".rst_inst"}, 64'(inst), 64'd0);
            check({nm, ".rst_imm"}, imm, 64'd0);
            check({nm, ".rst_fmt"}, 64'(fmt), 64'd0);
            check({nm, ".rst_ill"}, 64'(ill), 64'd0);
        end else if (q.size() > 0) begin
            ref_dec(q[0], xlen, ei, ef, el);
            check({nm, ".inst"}, 64'(inst), 64'(q[0]));
            check({nm, ".imm"}, imm, ei);
            check({nm, ".fmt"}, 64'(fmt), 64'(ef));
            check({nm, ".ill"}, 64'(ill), 64'(el));
        end
    endtask

    task automatic cycle();
        logic acc;
        acc = iv && exp_rdy;
        if (rs) begin
            q.delete();
            exp_rdy = 1'b0;
        end else if (fl) begin
            q.delete();
            exp_rdy = 1'b1;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (acc) q.push_back(ii);
            exp_rdy = (q.size() < 2);
        end
        was_rst = rs;
        @(posedge clk);
        #1;
        chk_dut("d32", 32, b32.out_valid, b32.in_ready, b32.out_inst,
                64'(b32.out_imm), b32.out_fmt, b32.out_illegal);
        chk_dut("d64", 64, b64.out_valid, b64.in_ready, b64.out_inst,
                b64.out_imm, b64.out_fmt, b64.out_illegal);
    endtask

    task automatic send(input logic [31:0] x);
        iv = 1'b1; ii = x; ordy = 1'b1; fl = 1'b0;
        cycle();
        iv = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        int k;
        x = $urandom();
        k = $urandom_range(0, 13);
        case (k)
            0: x[6:0] = 7'h03;  1: x[6:0] = 7'h67;
            2: x[6:0] = 7'h0F;  3: x[6:0] = 7'h13;
            4: x[6:0] = 7'h23;  5: x[6:0] = 7'h63;
            6: x[6:0] = 7'h37;  7: x[6:0] = 7'h17;
            8: x[6:0] = 7'h6F;  9: x[6:0] = 7'h73;
            10: x[6:0] = 7'h33;
            11: begin
                x[6:0] = 7'h13;
                x[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
                x[31:26] = $urandom_range(0, 1) ? 6'h00 : 6'h10;
            end
            default: ;
        endcase
        return x;
    endfunction

    localparam logic [31:0] IA = 32'h00100093;
    localparam logic [31:0] IB = 32'h00200113;
    localparam logic [31:0] IC = 32'h00300193;

    initial begin
        rs = 1'b1; fl = 1'b0; iv = 1'b0; ordy = 1'b0; ii = '0;
        exp_rdy = 1'b0; was_rst = 1'b0;
        cycle();
        cycle();
        rs = 1'b0;
        cycle();
        check("ready_after_rst", 64'(b32.in_ready), 64'd1);

        send(32'hFFF00093);
        check("addi.imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        check("addi.fmt", 64'(b32.out_fmt), 64'd1);
        check("addi.ill", 64'(b32.out_illegal), 64'd0);
        check("addi.imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'hFE000EE3);
        check("beq4.imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
        check("beq4.fmt", 64'(b32.out_fmt), 64'd3);
        send(32'hFE000FE3);
        check("beq2.imm", 64'(b32.out_imm), 64'hFFFF_FFFE);
        send(32'h123450B7);
        check("lui.imm", 64'(b32.out_imm), 64'h1234_5000);
        check("lui.fmt", 64'(b32.out_fmt), 64'd4);
        send(32'h4030D093);
        check("srai.imm", 64'(b32.out_imm), 64'd3);
        check("srai.fmt", 64'(b32.out_fmt), 64'd6);
        send(32'h00000000);
        check("zero.ill", 64'(b32.out_illegal), 64'd1);
        check("zero.imm", 64'(b32.out_imm), 64'd0);
        send(32'h02009093);
        check("slli64.imm", b64.out_imm, 64'd32);
        check("slli64.ill", 64'(b64.out_illegal), 64'd0);
        check("slli32.ill", 64'(b32.out_illegal), 64'd1);
        check("slli32.imm", 64'(b32.out_imm), 64'd0);

        ordy = 1'b1;
        cycle();
        ordy = 1'b0; iv = 1'b1; ii = IA;
        cycle();
        check("bp.A_in_O", 64'(b32.out_inst), 64'(IA));
        ii = IB;
        cycle();
        check("bp.ready_low", 64'(b32.in_ready), 64'd0);
        ii = IC;
        cycle();
        check("bp.C_held", 64'(b32.out_inst), 64'(IA));
        ordy = 1'b1;
        cycle();
        check("bp.B_out", 64'(b32.out_inst), 64'(IB));
        cycle();
        check("bp.C_out", 64'(b32.out_inst), 64'(IC));
        iv = 1'b0;
        cycle();
        check("bp.empty", 64'(b32.out_valid), 64'd0);

        ordy = 1'b0; iv = 1'b1; ii = IA;
        cycle();
        ii = IB;
        cycle();
        fl = 1'b1; ii = IC;
        cycle();
        check("fl.valid", 64'(b32.out_valid), 64'd0);
        check("fl.ready", 64'(b32.in_ready), 64'd1);
        fl = 1'b0; iv = 1'b0; ordy = 1'b1;
        cycle();
        cycle();
        check("fl.no_ghost", 64'(b32.out_valid), 64'd0);

        ordy = 1'b0; iv = 1'b1; ii = IA;
        cycle();
        ii = IB;
        cycle();
        iv = 1'b0; rs = 1'b1;
        cycle();
        check("rst.ready", 64'(b32.in_ready), 64'd0);
        check("rst.valid", 64'(b64.out_valid), 64'd0);
        rs = 1'b0;
        cycle();
        check("rst.ready_after", 64'(b64.in_ready), 64'd1);

        for (int i = 0; i < 1200; i++) begin
            int pr;
            pr   = (i / 200) % 2 == 0 ? 70 : 25;
            rs   = ($urandom_range(0, 99) < 2);
            fl   = ($urandom_range(0, 99) < 4);
            iv   = ($urandom_range(0, 99) < 75);
            ordy = ($urandom_range(0, 99) < pr);
            ii   = rand_inst();
            cycle();
        end

        rs = 1'b0; fl = 1'b0; iv = 1'b0; ordy = 1'b1;
        cycle();
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
